pipe_ctrl_n: RTL and testbench
==============================

Name: pipe_ctrl_n

Overview:
- Parametrised successor to the 5-stage pipeline stall/flush controller.
- Supports an arbitrary stage count and multi-cycle flush windows.
- Defers an exception flush while an outstanding bus transaction is stalling the core, and registers the redirect PC.
- Sits beside the stage modules in the CPU top; drives their stall vector, flush and redirect, and exposes saturating stall/flush performance counters.

Parameters:
- NSTAGE, 5: number of pipeline stages (index 0 = IF, NSTAGE-1 = WB). Legal range 2..16.
- FLUSH_CYC, 1: cycles flush stays asserted per exception event, >=1.
- PC_W, 64: PC width.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- stallreq  in  NSTAGE  per-stage stall request; bit k from stage k
- stallreq_bus  in  1  external bus (AXI) stall; freezes the whole pipe
- except_en  in  1  exception/trap commit pulse from MEM
- except_pc  in  PC_W  trap target, valid with except_en
- cnt_clr  in  1  synchronous clear of both counters
- stall  out  NSTAGE+1  bit 0 = PC hold; bit i+1 = hold of the stage-i output register
- flush  out  1  kill all in-flight stage registers
- redirect_valid  out  1  load PC from redirect_pc (coincident with the first flush cycle)
- redirect_pc  out  PC_W  redirect target
- busy_pend  out  1  flush pending behind bus stall
- stall_cnt  out  CNT_W  cycles with any stall bit set
- flush_cnt  out  CNT_W  flush events

Behaviour:

Reset:
- State RUN.
- stall=0, flush=0, redirect_valid=0, redirect_pc=0, busy_pend=0, counters=0.
- Latched PC cleared.
- Reset during PEND or FLUSH drops the pending or ongoing flush.

Stall vector (combinational, in RUN only):
- stallreq_bus=1 -> stall = all ones.
- Else let k = highest set index in stallreq. Then stall[k+1:0] = ones and the upper bits are 0.
- No request -> stall = 0.
- Example, NSTAGE=5: stallreq[1] (ID) -> 6'b000111; stallreq[2] (EX) -> 6'b001111.

States RUN / PEND / FLUSH:
- RUN, except_en=1 and stallreq_bus=0:
  - flush=1, redirect_valid=1, redirect_pc=except_pc in the same cycle (zero latency).
  - stall=0 that cycle (flush overrides stall).
  - Next state: FLUSH if FLUSH_CYC>1 (load remaining count FLUSH_CYC-1), else RUN.
- RUN, except_en=1 and stallreq_bus=1:
  - Latch except_pc, go to PEND.
  - flush=0, stall=all ones.
- PEND:
  - busy_pend=1, stall=all ones, flush=0.
  - Further except_en is ignored; the first exception wins.
  - On the first cycle with stallreq_bus=0: flush=1, redirect_valid=1, redirect_pc=latched PC, stall=0.
  - Then go to FLUSH or RUN, per the FLUSH_CYC rule above.
- FLUSH:
  - flush=1, redirect_valid=0, stall=0.
  - except_en is ignored.
  - Count decrements each cycle; go to RUN after the cycle in which count reaches 1.
  - stallreq_bus during FLUSH does not extend the flush; stall stays 0, since the bus stall is honoured only in RUN/PEND.
- redirect_pc holds its last value when redirect_valid=0.

Counters:
- stall_cnt: +1 each cycle stall!=0.
- flush_cnt: +1 on each cycle with redirect_valid=1.
- Both saturate at all ones; no wrap.
- cnt_clr has priority over increment and clears to 0 the next cycle.
- Counters are registered; their value reflects events up to the previous edge.

Test Plan:
- NSTAGE=5: stallreq=5'b00110 for 3 cycles -> stall=6'b001111 each cycle; stall_cnt=3 afterwards; flush=0.
- FLUSH_CYC=2, except_en pulse with except_pc=0x8000_0100 while stallreq[2]=1 -> that cycle flush=1, redirect_valid=1, redirect_pc=0x8000_0100, stall=0; next cycle flush=1, redirect_valid=0; third cycle flush=0; flush_cnt=1.
- stallreq_bus=1 for 4 cycles; except_en pulse (pc=0x8000_0200) in cycle 1 and a second except_en (pc=0x8000_0300) in cycle 2 -> busy_pend=1 and stall=6'h3F through cycle 3; in cycle 4 (bus low) flush=1, redirect_pc=0x8000_0200; flush_cnt increments by exactly 1.
- rst asserted while in PEND -> next cycle busy_pend=0, flush=0, stall=0, redirect_pc=0; no flush occurs after the bus drops.
- CNT_W=4, stallreq_bus held 20 cycles -> stall_cnt saturates at 4'hF; cnt_clr pulse -> 0 next cycle, then resumes counting.
- NSTAGE=8, stallreq=8'h80 -> stall=9'h1FF; stallreq=8'h01 -> stall=9'h003.

Source files
------------

// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - parametrised pipeline stall/flush controller with deferred exception flush
//
// Purpose: drives the per-stage stall vector, the flush strobe and the PC
// redirect for an NSTAGE-deep pipeline. An exception that commits while the
// external bus is stalling the core is held pending until the bus releases.
// Saturating counters report stall cycles and flush events.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   stallreq        per-stage stall request, bit k from stage k (0 = IF)
//   stallreq_bus    external bus stall, freezes the whole pipe
//   except_en       exception/trap commit pulse
//   except_pc       trap target, valid with except_en
//   cnt_clr         synchronous clear of both performance counters
//   stall           bit 0 = PC hold, bit i+1 = hold of stage-i output register
//   flush           kill all in-flight stage registers
//   redirect_valid  load PC from redirect_pc (first flush cycle only)
//   redirect_pc     redirect target, holds last value otherwise
//   busy_pend       exception flush waiting behind a bus stall
//   stall_cnt       cycles with any stall bit set (saturating)
//   flush_cnt       flush events (saturating)

module pipe_ctrl_n #(
    parameter int NSTAGE    = 5,
    parameter int FLUSH_CYC = 1,
    parameter int PC_W      = 64,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              stallreq_bus,
    input  logic              except_en,
    input  logic [PC_W-1:0]   except_pc,
    input  logic              cnt_clr,
    output logic [NSTAGE:0]   stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              busy_pend,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int             FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [1:0]     S_AFTER = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;

    logic [1:0]      r_state;
    logic [FC_W-1:0] r_fcnt;
    logic [PC_W-1:0] r_pc_latch;
    logic [PC_W-1:0] r_redirect_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [NSTAGE:0] w_req_mask;
    logic            w_acc;
    logic [1:0]      w_next_state;
    logic [FC_W-1:0] w_fcnt_next;
    logic [NSTAGE:0] w_stall;
    logic            w_flush;
    logic            w_redirect;
    logic [PC_W-1:0] w_target;
    logic            w_latch;

    // Thermometer mask: every bit at or below (highest requesting stage + 1)
    // is set, so a stalled stage also holds everything upstream of it.
    always_comb begin
        w_acc      = 1'b0;
        w_req_mask = '0;
        for (int j = NSTAGE; j >= 1; j--) begin
            w_acc         = w_acc | stallreq[j-1];
            w_req_mask[j] = w_acc;
        end
        w_req_mask[0] = w_acc;
    end

    always_comb begin
        w_next_state = r_state;
        w_fcnt_next  = r_fcnt;
        w_stall      = '0;
        w_flush      = 1'b0;
        w_redirect   = 1'b0;
        w_target     = r_pc_latch;
        w_latch      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (except_en && !stallreq_bus) begin
                    w_flush      = 1'b1;
                    w_redirect   = 1'b1;
                    w_target     = except_pc;
                    w_next_state = S_AFTER;
                    w_fcnt_next  = FC_LOAD;
                end else if (except_en) begin
                    // Bus owns the core: remember the target, flush later.
                    w_latch      = 1'b1;
                    w_stall      = '1;
                    w_next_state = S_PEND;
                end else if (stallreq_bus) begin
                    w_stall = '1;
                end else begin
                    w_stall = w_req_mask;
                end
            end
            S_PEND: begin
                if (!stallreq_bus) begin
                    w_flush      = 1'b1;
                    w_redirect   = 1'b1;
                    w_target     = r_pc_latch;
                    w_next_state = S_AFTER;
                    w_fcnt_next  = FC_LOAD;
                end else begin
                    w_stall = '1;
                end
            end
            S_FLUSH: begin
                // Fixed-length window; neither bus stall nor new traps extend it.
                w_flush     = 1'b1;
                w_fcnt_next = r_fcnt - FC_W'(1);
                if (r_fcnt == FC_W'(1)) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_fcnt        <= '0;
            r_pc_latch    <= '0;
            r_redirect_pc <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_fcnt  <= w_fcnt_next;
            if (w_latch) begin
                r_pc_latch <= except_pc;
            end
            if (w_redirect) begin
                r_redirect_pc <= w_target;
            end
            if (cnt_clr) begin
                r_stall_cnt <= '0;
            end else if ((|w_stall) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (cnt_clr) begin
                r_flush_cnt <= '0;
            end else if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall          = w_stall;
    assign flush          = w_flush;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_redirect ? w_target : r_redirect_pc;
    assign busy_pend      = (r_state == S_PEND);
    assign stall_cnt      = r_stall_cnt;
    assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - self-checking bench for pipe_ctrl_n in three parameterisations
module tb_pipe_ctrl_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A: NSTAGE=5, FLUSH_CYC=2, PC_W=64, CNT_W=32
    logic [4:0]  a_sr;
    logic        a_bus, a_ex, a_clr;
    logic [63:0] a_pc;
    logic [5:0]  a_stall;
    logic        a_flush, a_rv, a_busy;
    logic [63:0] a_rpc;
    logic [31:0] a_sc, a_fc;

    pipe_ctrl_n #(.NSTAGE(5), .FLUSH_CYC(2), .PC_W(64), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .stallreq(a_sr), .stallreq_bus(a_bus),
        .except_en(a_ex), .except_pc(a_pc), .cnt_clr(a_clr),
        .stall(a_stall), .flush(a_flush), .redirect_valid(a_rv),
        .redirect_pc(a_rpc), .busy_pend(a_busy), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    // Instance B: NSTAGE=5, FLUSH_CYC=1, PC_W=16, CNT_W=4
    logic [4:0]  b_sr;
    logic        b_bus, b_ex, b_clr;
    logic [15:0] b_pc;
    logic [5:0]  b_stall;
    logic        b_flush, b_rv, b_busy;
    logic [15:0] b_rpc;
    logic [3:0]  b_sc, b_fc;

    pipe_ctrl_n #(.NSTAGE(5), .FLUSH_CYC(1), .PC_W(16), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .stallreq(b_sr), .stallreq_bus(b_bus),
        .except_en(b_ex), .except_pc(b_pc), .cnt_clr(b_clr),
        .stall(b_stall), .flush(b_flush), .redirect_valid(b_rv),
        .redirect_pc(b_rpc), .busy_pend(b_busy), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    // Instance C: NSTAGE=8, FLUSH_CYC=3, PC_W=32, CNT_W=8
    logic [7:0]  c_sr;
    logic        c_bus, c_ex, c_clr;
    logic [31:0] c_pc;
    logic [8:0]  c_stall;
    logic        c_flush, c_rv, c_busy;
    logic [31:0] c_rpc;
    logic [7:0]  c_sc, c_fc;

    pipe_ctrl_n #(.NSTAGE(8), .FLUSH_CYC(3), .PC_W(32), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .stallreq(c_sr), .stallreq_bus(c_bus),
        .except_en(c_ex), .except_pc(c_pc), .cnt_clr(c_clr),
        .stall(c_stall), .flush(c_flush), .redirect_valid(c_rv),
        .redirect_pc(c_rpc), .busy_pend(c_busy), .stall_cnt(c_sc), .flush_cnt(c_fc)
    );

    typedef struct packed {
        logic [4:0]  sr;
        logic        bus, ex, rst;
        logic [63:0] pc;
        logic [5:0]  es;
        logic        ef, erv, eb;
        logic [63:0] epc;
    } row_a_t;

    typedef struct packed {
        logic        bus, ex, clr;
        logic [15:0] pc;
        logic [5:0]  es;
        logic        ef, erv;
        logic [15:0] epc;
    } row_b_t;

    typedef struct packed {
        logic [7:0]  sr;
        logic        ex;
        logic [31:0] pc;
        logic [8:0]  es;
        logic        ef, erv;
        logic [31:0] epc;
    } row_c_t;

    // Scoreboards: expected observation per cycle, pushed when driven.
    logic [136:0] sb_a[$];
    logic [31:0]  sb_b[$];
    logic [42:0]  sb_c[$];
    logic [136:0] exp_a, got_a;
    logic [31:0]  exp_b, got_b;
    logic [42:0]  exp_c, got_c;

    logic [31:0] m_sc_a = 0, m_fc_a = 0;
    logic [3:0]  m_sc_b = 0, m_fc_b = 0;

    function automatic row_a_t mk_a(input logic [4:0] sr, input logic bus, input logic ex,
                                    input logic rs, input logic [63:0] pc, input logic [5:0] es,
                                    input logic ef, input logic erv, input logic eb,
                                    input logic [63:0] epc);
        row_a_t r;
        r.sr = sr; r.bus = bus; r.ex = ex; r.rst = rs; r.pc = pc;
        r.es = es; r.ef = ef; r.erv = erv; r.eb = eb; r.epc = epc;
        return r;
    endfunction

    function automatic row_b_t mk_b(input logic bus, input logic ex, input logic clr,
                                    input logic [15:0] pc, input logic [5:0] es,
                                    input logic ef, input logic erv, input logic [15:0] epc);
        row_b_t r;
        r.bus = bus; r.ex = ex; r.clr = clr; r.pc = pc;
        r.es = es; r.ef = ef; r.erv = erv; r.epc = epc;
        return r;
    endfunction

    function automatic row_c_t mk_c(input logic [7:0] sr, input logic ex, input logic [31:0] pc,
                                    input logic [8:0] es, input logic ef, input logic erv,
                                    input logic [31:0] epc);
        row_c_t r;
        r.sr = sr; r.ex = ex; r.pc = pc;
        r.es = es; r.ef = ef; r.erv = erv; r.epc = epc;
        return r;
    endfunction

    // Stimulus side: apply inputs, push expectation, advance counter model.
    task automatic drive_a(input row_a_t r);
        a_sr = r.sr; a_bus = r.bus; a_ex = r.ex; a_pc = r.pc; a_clr = 1'b0; rst = r.rst;
        sb_a.push_back({r.es, r.ef, r.erv, r.eb, r.epc, m_sc_a, m_fc_a});
        if (r.rst) begin
            m_sc_a = 0; m_fc_a = 0;
        end else begin
            if (r.es != 6'h00) m_sc_a = m_sc_a + 1;
            if (r.erv) m_fc_a = m_fc_a + 1;
        end
    endtask

    task automatic drive_b(input row_b_t r);
        b_bus = r.bus; b_ex = r.ex; b_clr = r.clr; b_pc = r.pc; b_sr = 5'h00; rst = 1'b0;
        sb_b.push_back({r.es, r.ef, r.erv, r.epc, m_sc_b, m_fc_b});
        if (r.clr) begin
            m_sc_b = 0; m_fc_b = 0;
        end else begin
            if (r.es != 6'h00 && m_sc_b != 4'hF) m_sc_b = m_sc_b + 1;
            if (r.erv && m_fc_b != 4'hF) m_fc_b = m_fc_b + 1;
        end
    endtask

    task automatic drive_c(input row_c_t r);
        c_sr = r.sr; c_ex = r.ex; c_pc = r.pc; c_bus = 1'b0; c_clr = 1'b0; rst = 1'b0;
        sb_c.push_back({r.es, r.ef, r.erv, r.epc});
    endtask

    task automatic test_reset;
        row_a_t rq[$];
        rq.push_back(mk_a(5'h00, 0, 0, 0, 64'h0, 6'h00, 0, 0, 0, 64'h0));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_a(rq[i]); @(negedge clk);
            exp_a = sb_a.pop_front();
            got_a = {a_stall, a_flush, a_rv, a_busy, a_rpc, a_sc, a_fc};
            n_cmp++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL test_reset[%0d] got=%h exp=%h", i, got_a, exp_a);
            end
        end
        n_cmp++;
        if ({b_stall, b_flush, b_busy, b_rpc, b_sc, b_fc} !== 32'h0) begin
            n_fail++;
            $display("FAIL test_reset_b got=%h exp=0", {b_stall, b_flush, b_busy, b_rpc, b_sc, b_fc});
        end
    endtask

    task automatic test_stall_vec;
        row_a_t rq[$];
        for (int k = 0; k < 3; k++)
            rq.push_back(mk_a(5'b00110, 0, 0, 0, 64'h0, 6'b001111, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b00000, 0, 0, 0, 64'h0, 6'b000000, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b00010, 0, 0, 0, 64'h0, 6'b000111, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b00001, 0, 0, 0, 64'h0, 6'b000011, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b10001, 0, 0, 0, 64'h0, 6'b111111, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b00000, 1, 0, 0, 64'h0, 6'b111111, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'b00000, 0, 0, 0, 64'h0, 6'b000000, 0, 0, 0, 64'h0));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_a(rq[i]); @(negedge clk);
            exp_a = sb_a.pop_front();
            got_a = {a_stall, a_flush, a_rv, a_busy, a_rpc, a_sc, a_fc};
            n_cmp++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL test_stall_vec[%0d] got=%h exp=%h", i, got_a, exp_a);
            end
        end
    endtask

    task automatic test_flush;
        row_a_t rq[$];
        rq.push_back(mk_a(5'b00100, 0, 1, 0, 64'h8000_0100, 6'h00, 1, 1, 0, 64'h8000_0100));
        rq.push_back(mk_a(5'b00100, 0, 1, 0, 64'h8000_0999, 6'h00, 1, 0, 0, 64'h8000_0100));
        rq.push_back(mk_a(5'b00100, 0, 0, 0, 64'h0,         6'h0F, 0, 0, 0, 64'h8000_0100));
        rq.push_back(mk_a(5'b00000, 0, 0, 0, 64'h0,         6'h00, 0, 0, 0, 64'h8000_0100));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_a(rq[i]); @(negedge clk);
            exp_a = sb_a.pop_front();
            got_a = {a_stall, a_flush, a_rv, a_busy, a_rpc, a_sc, a_fc};
            n_cmp++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL test_flush[%0d] got=%h exp=%h", i, got_a, exp_a);
            end
        end
    endtask

    task automatic test_pend;
        row_a_t rq[$];
        rq.push_back(mk_a(5'h00, 1, 1, 0, 64'h8000_0200, 6'h3F, 0, 0, 0, 64'h8000_0100));
        rq.push_back(mk_a(5'h00, 1, 1, 0, 64'h8000_0300, 6'h3F, 0, 0, 1, 64'h8000_0100));
        rq.push_back(mk_a(5'h00, 1, 0, 0, 64'h0,         6'h3F, 0, 0, 1, 64'h8000_0100));
        rq.push_back(mk_a(5'h00, 0, 0, 0, 64'h0,         6'h00, 1, 1, 1, 64'h8000_0200));
        rq.push_back(mk_a(5'h00, 1, 0, 0, 64'h0,         6'h00, 1, 0, 0, 64'h8000_0200));
        rq.push_back(mk_a(5'h00, 1, 0, 0, 64'h0,         6'h3F, 0, 0, 0, 64'h8000_0200));
        rq.push_back(mk_a(5'h00, 0, 0, 0, 64'h0,         6'h00, 0, 0, 0, 64'h8000_0200));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_a(rq[i]); @(negedge clk);
            exp_a = sb_a.pop_front();
            got_a = {a_stall, a_flush, a_rv, a_busy, a_rpc, a_sc, a_fc};
            n_cmp++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL test_pend[%0d] got=%h exp=%h", i, got_a, exp_a);
            end
        end
    endtask

    task automatic test_reset_in_pend;
        row_a_t rq[$];
        rq.push_back(mk_a(5'h00, 1, 1, 0, 64'h8000_0400, 6'h3F, 0, 0, 0, 64'h8000_0200));
        rq.push_back(mk_a(5'h00, 1, 0, 1, 64'h0,         6'h3F, 0, 0, 1, 64'h8000_0200));
        rq.push_back(mk_a(5'h00, 0, 0, 0, 64'h0,         6'h00, 0, 0, 0, 64'h0));
        rq.push_back(mk_a(5'h00, 0, 0, 0, 64'h0,         6'h00, 0, 0, 0, 64'h0));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_a(rq[i]); @(negedge clk);
            exp_a = sb_a.pop_front();
            got_a = {a_stall, a_flush, a_rv, a_busy, a_rpc, a_sc, a_fc};
            n_cmp++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL test_reset_in_pend[%0d] got=%h exp=%h", i, got_a, exp_a);
            end
        end
    endtask

    task automatic test_saturate;
        row_b_t rq[$];
        m_sc_b = 0; m_fc_b = 0;
        for (int k = 0; k < 20; k++)
            rq.push_back(mk_b(1, 0, 0, 16'h0, 6'h3F, 0, 0, 16'h0));
        rq.push_back(mk_b(1, 0, 1, 16'h0,    6'h3F, 0, 0, 16'h0));
        rq.push_back(mk_b(1, 0, 0, 16'h0,    6'h3F, 0, 0, 16'h0));
        rq.push_back(mk_b(0, 0, 0, 16'h0,    6'h00, 0, 0, 16'h0));
        rq.push_back(mk_b(0, 1, 0, 16'h1234, 6'h00, 1, 1, 16'h1234));
        rq.push_back(mk_b(0, 0, 0, 16'h0,    6'h00, 0, 0, 16'h1234));
        rq.push_back(mk_b(0, 0, 0, 16'h0,    6'h00, 0, 0, 16'h1234));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_b(rq[i]); @(negedge clk);
            exp_b = sb_b.pop_front();
            got_b = {b_stall, b_flush, b_rv, b_rpc, b_sc, b_fc};
            n_cmp++;
            if (got_b !== exp_b) begin
                n_fail++;
                $display("FAIL test_saturate[%0d] got=%h exp=%h", i, got_b, exp_b);
            end
        end
    endtask

    task automatic test_wide_pipe;
        row_c_t rq[$];
        rq.push_back(mk_c(8'h80, 0, 32'h0,         9'h1FF, 0, 0, 32'h0));
        rq.push_back(mk_c(8'h01, 0, 32'h0,         9'h003, 0, 0, 32'h0));
        rq.push_back(mk_c(8'h11, 0, 32'h0,         9'h03F, 0, 0, 32'h0));
        rq.push_back(mk_c(8'h00, 0, 32'h0,         9'h000, 0, 0, 32'h0));
        rq.push_back(mk_c(8'h01, 1, 32'hDEAD_0000, 9'h000, 1, 1, 32'hDEAD_0000));
        rq.push_back(mk_c(8'h80, 0, 32'h0,         9'h000, 1, 0, 32'hDEAD_0000));
        rq.push_back(mk_c(8'h80, 1, 32'h1111_0000, 9'h000, 1, 0, 32'hDEAD_0000));
        rq.push_back(mk_c(8'h80, 0, 32'h0,         9'h1FF, 0, 0, 32'hDEAD_0000));
        foreach (rq[i]) begin
            @(posedge clk); #1; drive_c(rq[i]); @(negedge clk);
            exp_c = sb_c.pop_front();
            got_c = {c_stall, c_flush, c_rv, c_rpc};
            n_cmp++;
            if (got_c !== exp_c) begin
                n_fail++;
                $display("FAIL test_wide_pipe[%0d] got=%h exp=%h", i, got_c, exp_c);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_sr = '0; a_bus = 0; a_ex = 0; a_clr = 0; a_pc = '0;
        b_sr = '0; b_bus = 0; b_ex = 0; b_clr = 0; b_pc = '0;
        c_sr = '0; c_bus = 0; c_ex = 0; c_clr = 0; c_pc = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_stall_vec();
        test_flush();
        test_pend();
        test_reset_in_pend();
        test_saturate();
        test_wide_pipe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
